// File: rtl/pc_fetch_ctrl_pkg.sv
// Shared types for the fetch-stage sequencer.
//   pcsrc_t       : next-PC mux select codes driven on PCSrc.
//   fetch_state_t : sequencer states, also exposed on the dbg_state port.
//   counts_stall  : states in which a cycle without a PC load counts as a stall.
package pc_fetch_ctrl_pkg;

  typedef enum logic [2:0] {
    PC_SEQ    = 3'd0,
    PC_BRANCH = 3'd1,
    PC_JUMP   = 3'd2,
    PC_JR     = 3'd3,
    PC_HOLD   = 3'd4
  } pcsrc_t;

  typedef enum logic [2:0] {
    ST_RESET_WAIT = 3'd0,
    ST_FETCH      = 3'd1,
    ST_WAIT_D     = 3'd2,
    ST_REDIRECT   = 3'd3,
    ST_HALTED     = 3'd4
  } fetch_state_t;

  // RESET_WAIT and HALTED are idle by design; only the working states
  // accumulate stall cycles.
  function automatic logic counts_stall(input fetch_state_t s);
    return (s == ST_FETCH) || (s == ST_WAIT_D) || (s == ST_REDIRECT);
  endfunction

endpackage

// File: rtl/pc_fetch_ctrl_sat_counter.sv
// Saturating up-counter with synchronous clear.
//   clk   : clock, rising edge
//   clr   : synchronous clear (highest priority)
//   inc   : increment request; ignored once the counter is all ones
//   count : current value
module sat_counter #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         clr,
  input  logic         inc,
  output logic [W-1:0] count
);

  localparam logic [W-1:0] MAX_VAL = {W{1'b1}};
  localparam logic [W-1:0] ONE     = {{(W-1){1'b0}}, 1'b1};

  always_ff @(posedge clk) begin
    if (clr) begin
      count <= '0;
    end else if (inc && (count != MAX_VAL)) begin
      count <= count + ONE;
    end
  end

endmodule

// File: rtl/pc_fetch_ctrl.sv
// Fetch-stage sequencer for the pipelined MIPS PC datapath.
// Decides each cycle whether the PC loads, which next-PC source is used, and
// whether the shared cache port carries an instruction fetch. Data accesses
// from MEM own the port first; EX redirects are taken immediately when the
// fetch completes, otherwise parked in pend_src until it does.
//
// Ports:
//   CLK, RST        : clock, synchronous active-high reset
//   ihit, dhit      : instruction / data access completes this cycle
//   dmem_req        : MEM stage wants the port (dREN or dWEN)
//   hazard_stall    : load-use stall from the hazard unit
//   redir_valid     : EX resolves a taken branch / J / JAL / JR this cycle
//   redir_src       : PCSrc code for that redirect (never PC_SEQ)
//   halt            : HALT reached WB
//   pc_en, PCSrc    : PC load enable and next-PC select
//   iREN            : instruction read request
//   ifid_en         : IF/ID latch enable
//   ifid_flush      : zero IF/ID (wins over ifid_en inside the latch)
//   idex_flush      : zero ID/EX
//   halted          : sticky halt flag
//   stall_cnt       : saturating count of working-state cycles with pc_en=0
//   dbg_state       : current sequencer state
//
// Handshake: redir_valid is a one-cycle pulse with no ready; this block
// always consumes it in the cycle it is seen, either by loading the PC or by
// capturing redir_src into pend_src. halt is consumed the same way.
module pc_fetch_ctrl
  import pc_fetch_ctrl_pkg::*;
#(
  parameter int CNT_W = 16
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             ihit,
  input  logic             dhit,
  input  logic             dmem_req,
  input  logic             hazard_stall,
  input  logic             redir_valid,
  input  logic [2:0]       redir_src,
  input  logic             halt,
  output logic             pc_en,
  output logic [2:0]       PCSrc,
  output logic             iREN,
  output logic             ifid_en,
  output logic             ifid_flush,
  output logic             idex_flush,
  output logic             halted,
  output logic [CNT_W-1:0] stall_cnt,
  output fetch_state_t     dbg_state
);

  fetch_state_t state, state_nxt;
  pcsrc_t       pend_src, pend_src_nxt;
  logic         halted_nxt;
  pcsrc_t       pcsrc_sel;
  pcsrc_t       redir_code;

  logic advance;
  logic fetch_done;

  assign redir_code = pcsrc_t'(redir_src);

  assign advance = ihit & ~hazard_stall & ~(dmem_req & ~dhit);
  // The port is handed to data whenever dmem_req is up, so an ihit seen in
  // that cycle cannot belong to us even if dhit arrives alongside it.
  assign fetch_done = advance & ~dmem_req;

  always_ff @(posedge CLK) begin
    if (RST) begin
      state    <= ST_RESET_WAIT;
      pend_src <= PC_SEQ;
      halted   <= 1'b0;
    end else begin
      state    <= state_nxt;
      pend_src <= pend_src_nxt;
      halted   <= halted_nxt;
    end
  end

  always_comb begin
    state_nxt    = state;
    pend_src_nxt = pend_src;
    halted_nxt   = halted;
    pc_en        = 1'b0;
    pcsrc_sel    = PC_SEQ;
    iREN         = 1'b0;
    ifid_en      = 1'b0;
    ifid_flush   = 1'b0;
    idex_flush   = 1'b0;

    unique case (state)
      ST_RESET_WAIT: begin
        state_nxt = ST_FETCH;
      end

      ST_FETCH: begin
        iREN = ~dmem_req;
        if (halt) begin
          ifid_flush = 1'b1;
          state_nxt  = ST_HALTED;
          halted_nxt = 1'b1;
        end else if (redir_valid) begin
          ifid_flush = 1'b1;
          idex_flush = 1'b1;
          pcsrc_sel  = redir_code;
          if (fetch_done) begin
            pc_en   = 1'b1;
            ifid_en = 1'b1;
          end else begin
            pend_src_nxt = redir_code;
            state_nxt    = ST_REDIRECT;
          end
        end else begin
          pc_en   = fetch_done;
          ifid_en = fetch_done;
          if (dmem_req && !dhit) begin
            state_nxt = ST_WAIT_D;
          end
        end
      end

      ST_WAIT_D: begin
        if (halt) begin
          ifid_flush = 1'b1;
          state_nxt  = ST_HALTED;
          halted_nxt = 1'b1;
        end else if (redir_valid) begin
          // PC cannot load while waiting on data, so the redirect is parked.
          ifid_flush   = 1'b1;
          idex_flush   = 1'b1;
          pcsrc_sel    = redir_code;
          pend_src_nxt = redir_code;
          state_nxt    = ST_REDIRECT;
        end else if (dhit) begin
          state_nxt = ST_FETCH;
        end
      end

      ST_REDIRECT: begin
        iREN      = ~dmem_req;
        pcsrc_sel = pend_src;
        if (halt) begin
          pcsrc_sel  = PC_SEQ;
          ifid_flush = 1'b1;
          state_nxt  = ST_HALTED;
          halted_nxt = 1'b1;
        end else begin
          if (redir_valid) begin
            // A younger redirect replaces the parked one.
            ifid_flush   = 1'b1;
            idex_flush   = 1'b1;
            pcsrc_sel    = redir_code;
            pend_src_nxt = redir_code;
          end
          if (fetch_done) begin
            // The instruction returned now came from the wrong path.
            pc_en        = 1'b1;
            ifid_en      = 1'b1;
            ifid_flush   = 1'b1;
            pend_src_nxt = PC_SEQ;
            state_nxt    = ST_FETCH;
          end
        end
      end

      ST_HALTED: begin
        halted_nxt = 1'b1;
      end

      default: begin
        state_nxt = ST_RESET_WAIT;
      end
    endcase
  end

  assign PCSrc     = pcsrc_sel;
  assign dbg_state = state;

  sat_counter #(.W(CNT_W)) u_stall_cnt (
    .clk   (CLK),
    .clr   (RST),
    .inc   (counts_stall(state) & ~pc_en),
    .count (stall_cnt)
  );

  // A redirect to the sequential PC would be a decode bug upstream.
  a_redir_not_seq : assert property (
    @(posedge CLK) disable iff (RST) redir_valid |-> (redir_src != PC_SEQ)
  );

endmodule
